// File: rtl/asteroid_hit_control_if.sv
// Pixel-rate signals between the raster drawers and one asteroid's hit/lifecycle controller.
// The slave side is the controller; the master side drives the per-pixel requests.
interface asteroid_hit_control_if;
    logic startOfFrame;
    logic respawn;
    logic asteroidDR;
    logic missileDR;
    logic playerDR;
    logic asteroidIsHit;
    logic asteroidVisible;
    logic missileHit;
    logic playerHit;
    logic asteroidDestroyed;

    modport master (
        output startOfFrame, respawn, asteroidDR, missileDR, playerDR,
        input  asteroidIsHit, asteroidVisible, missileHit, playerHit, asteroidDestroyed
    );

    modport slave (
        input  startOfFrame, respawn, asteroidDR, missileDR, playerDR,
        output asteroidIsHit, asteroidVisible, missileHit, playerHit, asteroidDestroyed
    );
endinterface

// File: rtl/asteroid_hit_control.sv
// Per-asteroid hit/lifecycle controller: detects missile/player overlap during the raster scan,
// swaps to the explosion bitmap on frame boundaries and hides the asteroid until respawned.
module asteroid_hit_control #(
    parameter int unsigned EXPLOSION_FRAMES = 16,
    parameter int unsigned CNT_W            = 8
) (
    input logic                   clk,
    input logic                   resetN,
    asteroid_hit_control_if.slave bus
);

    typedef enum logic [1:0] {StAlive, StExploding, StDead} state_e;

    // A zero-frame explosion would never reach the cnt==1 exit, so it is built as one frame.
    localparam int unsigned      EffFrames = (EXPLOSION_FRAMES == 0) ? 1 : EXPLOSION_FRAMES;
    localparam logic [CNT_W-1:0] CntLoad   = CNT_W'(EffFrames);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    state_e           stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             mPendQ, mPendD, pPendQ, pPendD;
    logic             isHitQ, isHitD, visibleQ, visibleD;
    logic             mHitQ, mHitD, pHitQ, pHitD, destroyedQ, destroyedD;
    logic             mOv, pOv, lastFrame;

    assign mOv       = bus.asteroidDR & bus.missileDR;
    assign pOv       = bus.asteroidDR & bus.playerDR;
    assign lastFrame = (cntQ == CntOne);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateQ <= StAlive;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        if (bus.respawn) begin
            stateD = StAlive;
        end else if (bus.startOfFrame) begin
            case (stateQ)
                StAlive:     if (mPendQ | pPendQ) stateD = StExploding;
                StExploding: if (lastFrame) stateD = StDead;
                default:     stateD = stateQ;
            endcase
        end
    end

    always_comb begin
        isHitD     = (stateD == StExploding);
        visibleD   = (stateD != StDead);
        mHitD      = 1'b0;
        pHitD      = 1'b0;
        destroyedD = (stateQ == StExploding) && (stateD == StDead);
        // Pending flags belong to the previous frame during startOfFrame, so they don't mask.
        if (!bus.respawn && stateQ == StAlive) begin
            mHitD = mOv & (bus.startOfFrame | ~mPendQ);
            pHitD = pOv & (bus.startOfFrame | ~pPendQ);
        end
    end

    always_comb begin
        cntD   = cntQ;
        mPendD = mPendQ;
        pPendD = pPendQ;
        if (bus.respawn) begin
            cntD   = '0;
            mPendD = 1'b0;
            pPendD = 1'b0;
        end else begin
            if (bus.startOfFrame) begin
                mPendD = 1'b0;
                pPendD = 1'b0;
                if (stateQ == StAlive && stateD == StExploding) begin
                    cntD = CntLoad;
                end else if (stateQ == StExploding) begin
                    cntD = cntQ - CntOne;
                end
            end
            if (stateQ == StAlive) begin
                mPendD = mPendD | mOv;
                pPendD = pPendD | pOv;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cntQ       <= '0;
            mPendQ     <= 1'b0;
            pPendQ     <= 1'b0;
            isHitQ     <= 1'b0;
            visibleQ   <= 1'b1;
            mHitQ      <= 1'b0;
            pHitQ      <= 1'b0;
            destroyedQ <= 1'b0;
        end else begin
            cntQ       <= cntD;
            mPendQ     <= mPendD;
            pPendQ     <= pPendD;
            isHitQ     <= isHitD;
            visibleQ   <= visibleD;
            mHitQ      <= mHitD;
            pHitQ      <= pHitD;
            destroyedQ <= destroyedD;
        end
    end

    assign bus.asteroidIsHit     = isHitQ;
    assign bus.asteroidVisible   = visibleQ;
    assign bus.missileHit        = mHitQ;
    assign bus.playerHit         = pHitQ;
    assign bus.asteroidDestroyed = destroyedQ;

endmodule
